// File: rtl/sha256_pkg.sv
// sha256_pkg: shared constants, tables and helpers for the SHA-256 round controller.
//   WRD_SIZE/BLK_SIZE/MSG_SIZE/NUM_ROUNDS : datapath geometry
//   K_TABLE   : 64 round constants
//   IV        : initial chaining hash, word 0 (H0) in the MSBs
//   state_t   : controller FSM states
//   small_sigma0/1 : message-schedule mixing functions
//   add_words : per-32-bit-word modular add of two 256-bit hashes
package sha256_pkg;

  localparam int WRD_SIZE   = 32;
  localparam int BLK_SIZE   = 256;
  localparam int MSG_SIZE   = 512;
  localparam int NUM_ROUNDS = 64;
  localparam int NUM_SCHED  = MSG_SIZE / WRD_SIZE;
  localparam int NUM_HWRD   = BLK_SIZE / WRD_SIZE;

  typedef logic [WRD_SIZE-1:0] word_t;

  localparam word_t K_TABLE [NUM_ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [BLK_SIZE-1:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_t;

  // ROTR7 ^ ROTR18 ^ SHR3
  function automatic word_t small_sigma0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  // ROTR17 ^ ROTR19 ^ SHR10
  function automatic word_t small_sigma1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Carries never cross word boundaries.
  function automatic logic [BLK_SIZE-1:0] add_words(input logic [BLK_SIZE-1:0] a,
                                                    input logic [BLK_SIZE-1:0] b);
    logic [BLK_SIZE-1:0] s;
    s = '0;
    for (int i = 0; i < NUM_HWRD; i++) begin
      s[i*WRD_SIZE +: WRD_SIZE] = a[i*WRD_SIZE +: WRD_SIZE] + b[i*WRD_SIZE +: WRD_SIZE];
    end
    return s;
  endfunction

endpackage

// File: rtl/sha_round_ctrl_if.sv
// sha_round_ctrl_if: bundles the host-side and round-datapath-side signals of the
// SHA-256 round controller.
//   master : host + round datapath view (drives i_*, observes o_*)
//   slave  : controller view (observes i_*, drives o_*)
interface sha_round_ctrl_if;
  import sha256_pkg::*;

  logic                i_start;
  logic                i_first_blk;
  logic [MSG_SIZE-1:0] i_msg_blck;
  logic [BLK_SIZE-1:0] i_round_hash;
  logic                o_round_en;
  logic [5:0]          o_round_idx;
  word_t               o_round_constant;
  word_t               o_msg_wrd;
  logic [BLK_SIZE-1:0] o_pre_blck_hash;
  logic                o_busy;
  logic                o_done;
  logic [BLK_SIZE-1:0] o_digest;

  modport master (
    output i_start, i_first_blk, i_msg_blck, i_round_hash,
    input  o_round_en, o_round_idx, o_round_constant, o_msg_wrd,
           o_pre_blck_hash, o_busy, o_done, o_digest
  );

  modport slave (
    input  i_start, i_first_blk, i_msg_blck, i_round_hash,
    output o_round_en, o_round_idx, o_round_constant, o_msg_wrd,
           o_pre_blck_hash, o_busy, o_done, o_digest
  );

endinterface

// File: rtl/sha_k_rom.sv
// sha_k_rom: combinational SHA-256 round-constant ROM.
//   addr : round index t (0..63)
//   k    : K[t]
module sha_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0] addr,
  output word_t      k
);

  assign k = K_TABLE[addr];

endmodule

// File: rtl/sha_round_ctrl.sv
// sha_round_ctrl: sequences one 512-bit block through 64 SHA-256 rounds, feeding
// K[t] and W[t] to the round datapath, then folds the round result into the
// chaining hash H and presents the digest.
//   clk     : clock, all state on rising edge
//   reset_n : asynchronous active-low reset
//   bus     : host start/message/digest and round-datapath signals (slave view)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for i_start; latches message words and optional IV
// LOAD  | round datapath loads working variables from o_pre_blck_hash
// ROUND | one round per cycle, t = 0..63
// FINAL | H += i_round_hash (per word), digest updated
// DONE  | o_done pulse
module sha_round_ctrl
  import sha256_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  sha_round_ctrl_if.slave bus
);

  localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

  state_t                       state_q, state_d;
  logic [5:0]                   idx_q;
  word_t [NUM_SCHED-1:0]        sched_q;
  word_t                        sched_next;
  logic [BLK_SIZE-1:0]          h_q;
  logic [BLK_SIZE-1:0]          digest_q;
  logic [BLK_SIZE-1:0]          h_sum;
  word_t                        k_word;
  logic                         start_accept;
  logic                         round_en;
  logic                         busy;
  logic                         done;

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and decoded outputs
  always_comb begin
    state_d      = state_q;
    start_accept = 1'b0;
    round_en     = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (bus.i_start) begin
          start_accept = 1'b1;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        state_d = ROUND;
      end
      ROUND: begin
        round_en = 1'b1;
        if (idx_q == LAST_ROUND) begin
          state_d = FINAL;
        end
      end
      FINAL: begin
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Round index: counts only inside ROUND and parks at 0 otherwise, so the
  // exit at 63 never wraps into a second pass.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q <= '0;
    end else if (round_en && (idx_q != LAST_ROUND)) begin
      idx_q <= idx_q + 6'd1;
    end else begin
      idx_q <= '0;
    end
  end

  // W[t+16] from the sliding 16-word window; sched_q[0] is always W[t].
  assign sched_next = small_sigma1(sched_q[14]) + sched_q[9]
                    + small_sigma0(sched_q[1]) + sched_q[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sched_q <= '0;
    end else if (start_accept) begin
      for (int i = 0; i < NUM_SCHED; i++) begin
        sched_q[i] <= bus.i_msg_blck[MSG_SIZE-1-i*WRD_SIZE -: WRD_SIZE];
      end
    end else if (round_en) begin
      sched_q <= {sched_next, sched_q[NUM_SCHED-1:1]};
    end
  end

  assign h_sum = add_words(h_q, bus.i_round_hash);

  // H only changes at block start (IV reload) or in FINAL, so an aborted block
  // never leaves a partial value behind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q      <= IV;
      digest_q <= '0;
    end else if (start_accept && bus.i_first_blk) begin
      h_q <= IV;
    end else if (state_q == FINAL) begin
      h_q      <= h_sum;
      digest_q <= h_sum;
    end
  end

  sha_k_rom u_k_rom (
    .addr (idx_q),
    .k    (k_word)
  );

  assign bus.o_round_en       = round_en;
  assign bus.o_round_idx      = idx_q;
  assign bus.o_round_constant = k_word;
  assign bus.o_msg_wrd        = sched_q[0];
  assign bus.o_pre_blck_hash  = h_q;
  assign bus.o_busy           = busy;
  assign bus.o_done           = done;
  assign bus.o_digest         = digest_q;

endmodule
